simple_bus: RTL and testbench



---
 rtl/simple_bus_pkg.sv | 23 ++
 rtl/simple_bus_follower.sv | 84 ++++++++
 rtl/simple_bus.sv | 123 ++++++++++++
 tb/tb_simple_bus.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared widths and FSM state types for the simple_bus leader/follower pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simple_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_ADDR_LO = 2'd1,
    L_RD_WAIT = 2'd2,
    L_WR_WAIT = 2'd3
  } leader_state_t;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_ADDR_LO = 2'd1,
    F_RD      = 2'd2,
    F_WR      = 2'd3
  } follower_state_t;

endpackage

// File: rtl/simple_bus_follower.sv
// simple_bus_follower: bus target; assembles a 16-bit address from two bus bytes, then serves a read or a write from its memory.
// Latency: read data is driven MEM_LATENCY cycles after entering F_RD; a write commits on the edge where bus_data_valid is seen.
// Backpressure: waits in F_WR for as long as the leader withholds bus_data_valid. Macro SIMPLE_BUS_MEM_INIT_EN zero-fills the memory.
module simple_bus_follower
  import simple_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int MEM_DEPTH   = 65536
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              bus_start,
  input  logic              bus_read,
  input  logic              bus_data_valid,
  input  logic [DATA_W-1:0] bus_address,
  input  logic [DATA_W-1:0] bus_data,
  output logic              drv_valid,
  output logic [DATA_W-1:0] drv_data
);

  localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  follower_state_t   state;
  logic [ADDR_W-1:0] address;
  logic [CNT_W-1:0]  wait_cnt;
  logic [IDX_W-1:0]  idx;
  logic              data_ready;

`ifdef SIMPLE_BUS_MEM_INIT_EN
  logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};
`else
  logic [DATA_W-1:0] mem [MEM_DEPTH];
`endif

  // Addresses beyond the memory size alias back into it.
  assign idx        = IDX_W'(32'(address) % MEM_DEPTH);
  assign data_ready = (state == F_RD) && (wait_cnt == CNT_W'(MEM_LATENCY));
  assign drv_valid  = data_ready;
  assign drv_data   = data_ready ? mem[idx] : '0;

  // Follower FSM: capture address bytes, count read latency, wait for write data.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= F_IDLE;
      address  <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        F_IDLE: begin
          if (bus_start) begin
            address[15:8] <= bus_address;
            state         <= F_ADDR_LO;
          end
        end
        F_ADDR_LO: begin
          address[7:0] <= bus_address;
          wait_cnt     <= '0;
          state        <= bus_read ? F_RD : F_WR;
        end
        F_RD: begin
          if (data_ready) begin
            wait_cnt <= '0;
            state    <= F_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        F_WR: begin
          if (bus_data_valid) state <= F_IDLE;
        end
        default: state <= F_IDLE;
      endcase
    end
  end

  // Memory write; a reset edge suppresses it so an aborted write leaves memory untouched.
  always_ff @(posedge clock) begin
    if (resetN && (state == F_WR) && bus_data_valid) begin
      mem[idx] <= bus_data;
    end
  end

endmodule

// File: rtl/simple_bus.sv
// simple_bus: leader FSM that turns an access request into a start/address-hi/address-lo/data sequence on an internal muxed bus.
// Latency: read idle again 3+MEM_LATENCY cycles after access, rdata_valid in that cycle; write commits end of cycle 2 if wdata_rdy high.
// Backpressure: access ignored while busy; wdata_rdy low stalls the write phase indefinitely. Macro SIMPLE_BUS_MEM_INIT_EN zero-fills memory.
module simple_bus
  import simple_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int MEM_DEPTH   = 65536
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              access,
  input  logic              do_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_rdy,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              bus_start,
  output logic              bus_read,
  output logic              bus_data_valid,
  output logic [DATA_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data
);

  leader_state_t     state;
  logic [DATA_W-1:0] addr_lo_q;
  logic              rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic              l_valid;
  logic [DATA_W-1:0] l_data;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;

  assign busy = (state != L_IDLE);

  // Leader-driven bus lines; everything is quiet while reset is asserted.
  always_comb begin
    bus_start   = 1'b0;
    bus_address = '0;
    bus_read    = 1'b0;
    l_valid     = 1'b0;
    l_data      = '0;
    if (resetN) begin
      unique case (state)
        L_IDLE: begin
          if (access) begin
            bus_start   = 1'b1;
            bus_address = addr[15:8];
          end
        end
        L_ADDR_LO: begin
          bus_address = addr_lo_q;
          bus_read    = rd_q;
        end
        L_WR_WAIT: begin
          if (wdata_rdy) begin
            l_valid = 1'b1;
            l_data  = wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  // The two agents never drive in the same cycle, so OR-muxing forms the shared lanes.
  assign bus_data_valid = l_valid | f_valid;
  assign bus_data       = l_data | f_data;

  // Leader FSM and read-data capture.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state       <= L_IDLE;
      addr_lo_q   <= '0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      unique case (state)
        L_IDLE: begin
          if (access) begin
            addr_lo_q <= addr[7:0];
            rd_q      <= do_read;
            wdata_q   <= wdata;
            state     <= L_ADDR_LO;
          end
        end
        L_ADDR_LO: state <= rd_q ? L_RD_WAIT : L_WR_WAIT;
        L_RD_WAIT: begin
          if (bus_data_valid) begin
            rdata       <= bus_data;
            rdata_valid <= 1'b1;
            state       <= L_IDLE;
          end
        end
        L_WR_WAIT: begin
          if (wdata_rdy) state <= L_IDLE;
        end
        default: state <= L_IDLE;
      endcase
    end
  end

  simple_bus_follower #(
    .MEM_LATENCY (MEM_LATENCY),
    .MEM_DEPTH   (MEM_DEPTH)
  ) u_follower (
    .clock          (clock),
    .resetN         (resetN),
    .bus_start      (bus_start),
    .bus_read       (bus_read),
    .bus_data_valid (bus_data_valid),
    .bus_address    (bus_address),
    .bus_data       (bus_data),
    .drv_valid      (f_valid),
    .drv_data       (f_data)
  );

endmodule

// File: tb/tb_simple_bus.sv
// tb_simple_bus: drives two simple_bus instances (default, and MEM_LATENCY=3 with a 256-byte memory) with identical stimulus.
// Expected per-cycle bus activity comes from the transaction timeline; memory contents come from associative-array models.
// Random access pulses and garbage inputs are applied while busy to confirm they are ignored.
module tb_simple_bus;

  typedef struct packed {
    logic       busy;
    logic       start;
    logic       rd;
    logic       dv;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] rdat;
    logic       rv;
  } obs_t;

  logic        clock = 1'b0;
  logic        resetN, access, do_read, wdata_rdy;
  logic [15:0] addr;
  logic [7:0]  wdata;

  logic       busy0, rv0, bs0, br0, dv0, busy3, rv3, bs3, br3, dv3;
  logic [7:0] rdat0, ba0, bd0, rdat3, ba3, bd3;
  obs_t       o0, o3;

  int errors = 0;
  int checks = 0;

  // Reference state: memory per instance (index is the wrapped address) and last read data.
  logic [7:0]  m0 [int];
  logic [7:0]  m3 [int];
  logic [7:0]  last0, last3;
  bit          lk0, lk3;
  logic [15:0] written [$];

  always #5 clock = ~clock;

  simple_bus dut0 (
    .clock(clock), .resetN(resetN), .access(access), .do_read(do_read), .addr(addr),
    .wdata(wdata), .wdata_rdy(wdata_rdy), .busy(busy0), .rdata(rdat0), .rdata_valid(rv0),
    .bus_start(bs0), .bus_read(br0), .bus_data_valid(dv0), .bus_address(ba0), .bus_data(bd0)
  );

  simple_bus #(.MEM_LATENCY(3), .MEM_DEPTH(256)) dut3 (
    .clock(clock), .resetN(resetN), .access(access), .do_read(do_read), .addr(addr),
    .wdata(wdata), .wdata_rdy(wdata_rdy), .busy(busy3), .rdata(rdat3), .rdata_valid(rv3),
    .bus_start(bs3), .bus_read(br3), .bus_data_valid(dv3), .bus_address(ba3), .bus_data(bd3)
  );

  assign o0 = {busy0, bs0, br0, dv0, ba0, bd0, rdat0, rv0};
  assign o3 = {busy3, bs3, br3, dv3, ba3, bd3, rdat3, rv3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected bus picture for cycle c of a transaction whose data phase is cycle e.
  task automatic check_obs(input string who, input int c, input obs_t o, input int e, input bit rd,
                           input logic [15:0] a, input bit dk, input logic [7:0] dexp,
                           input bit rk, input logic [7:0] rexp);
    string t;
    logic [7:0] exp_adr;
    t = $sformatf("%s c%0d", who, c);
    exp_adr = (c == 0) ? a[15:8] : (c == 1) ? a[7:0] : 8'h00;
    check({t, " busy"},  32'(o.busy),  32'(c >= 1 && c <= e));
    check({t, " start"}, 32'(o.start), 32'(c == 0));
    check({t, " addr"},  32'(o.adr),   32'(exp_adr));
    check({t, " read"},  32'(o.rd),    32'(c == 1 && rd));
    check({t, " dvld"},  32'(o.dv),    32'(c == e));
    if (c != e) check({t, " data"}, 32'(o.dat), 32'h0);
    else if (dk) check({t, " data"}, 32'(o.dat), 32'(dexp));
    check({t, " rvld"},  32'(o.rv),    32'(rd && c == e + 1));
    if (rk) check({t, " rdata"}, 32'(o.rdat), 32'(rexp));
  endtask

  task automatic run_txn(input bit rd, input logic [15:0] a, input logic [7:0] wd, input int stall);
    int e0, e3, last, i3;
    bit dk0, dk3;
    logic [7:0] d0, d3;
    i3 = int'(a) % 256;
    if (rd) begin
      e0  = 2;
      e3  = 5;
      dk0 = m0.exists(int'(a));
      dk3 = m3.exists(i3);
      d0  = dk0 ? m0[int'(a)] : 8'h00;
      d3  = dk3 ? m3[i3] : 8'h00;
    end else begin
      e0  = 2 + stall;
      e3  = e0;
      dk0 = 1'b1;
      dk3 = 1'b1;
      d0  = wd;
      d3  = wd;
    end
    last = e3 + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        access = 1'b1; do_read = rd; addr = a; wdata = wd;
      end else if (c <= e0) begin
        access  = 1'($urandom_range(0, 1));
        do_read = 1'($urandom_range(0, 1));
        addr    = 16'($urandom);
        wdata   = 8'($urandom);
      end else begin
        access = 1'b0;
      end
      if (rd) wdata_rdy = 1'($urandom_range(0, 1));
      else    wdata_rdy = !(c >= 2 && c < 2 + stall);
      @(negedge clock);
      check_obs("lat0", c, o0, e0, rd, a, dk0, d0,
                (rd && c > e0) ? dk0 : lk0, (rd && c > e0) ? d0 : last0);
      check_obs("lat3", c, o3, e3, rd, a, dk3, d3,
                (rd && c > e3) ? dk3 : lk3, (rd && c > e3) ? d3 : last3);
    end
    if (rd) begin
      lk0 = dk0; last0 = d0;
      lk3 = dk3; last3 = d3;
    end else begin
      m0[int'(a)] = wd;
      m3[i3]      = wd;
      written.push_back(a);
    end
  endtask

  initial begin
    resetN = 1'b0; access = 1'b1; do_read = 1'b0; addr = 16'hFFFF; wdata = 8'hFF; wdata_rdy = 1'b1;
    // Reset with access asserted: reset wins and every output stays zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset lat0 outputs", 32'(o0), 32'h0);
    check("reset lat3 outputs", 32'(o3), 32'h0);
    @(posedge clock);
    #1;
    resetN = 1'b1; access = 1'b0;
    lk0 = 1'b1; last0 = 8'h00; lk3 = 1'b1; last3 = 8'h00;

    run_txn(1'b0, 16'h1234, 8'hA5, 0);
    run_txn(1'b1, 16'h1234, 8'h00, 0);
    run_txn(1'b0, 16'h4321, 8'h77, 5);
    run_txn(1'b1, 16'h4321, 8'h00, 0);
    // Aliasing in the 256-byte instance: 0x0105 and 0x0005 share a word.
    run_txn(1'b0, 16'h0105, 8'h3C, 0);
    run_txn(1'b1, 16'h0005, 8'h00, 0);

    // Reset while stalled in the write phase, with wdata_rdy rising on the reset edge.
    @(posedge clock);
    #1;
    access = 1'b1; do_read = 1'b0; addr = 16'h1234; wdata = 8'h5A; wdata_rdy = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock);
      #1;
      access = 1'b1; addr = 16'($urandom);
      if (c == 3) begin
        resetN = 1'b0; wdata_rdy = 1'b1;
      end
      @(negedge clock);
      if (c < 3) begin
        check($sformatf("stall c%0d lat0 busy", c), 32'(busy0), 32'h1);
        check($sformatf("stall c%0d lat3 busy", c), 32'(busy3), 32'h1);
        if (c == 2) check("stall lat0 dvld", 32'(dv0), 32'h0);
      end
    end
    @(posedge clock);
    #1;
    resetN = 1'b1; access = 1'b0;
    @(negedge clock);
    check("after abort lat0 outputs", 32'(o0), 32'h0);
    check("after abort lat3 outputs", 32'(o3), 32'h0);
    lk0 = 1'b1; last0 = 8'h00; lk3 = 1'b1; last3 = 8'h00;
    run_txn(1'b1, 16'h1234, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      bit rd;
      logic [15:0] a;
      rd = 1'($urandom_range(0, 1));
      if (rd && written.size() > 0 && $urandom_range(0, 3) != 0)
        a = written[$urandom_range(0, written.size() - 1)];
      else
        a = 16'($urandom);
      run_txn(rd, a, 8'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
